mc_run_controller: RTL
======================

# mc_run_controller

Run sequencer for the five-lane Monte Carlo option-pricing engine.
- Accepts a start command with a per-lane sample target and drives the shared accumulate-enable (`Status`) and accumulator-clear (`Mode`) lines of all lanes.
- Waits out pipeline fill and drain, then captures the merged sum and sum-of-squares into stable result registers with a sample count.
- Sits between the host interface registers and the lane/merge datapath.

## Interface
- `LANES`, 5, number of parallel NormalGenerator/PresentValue/math lanes.
- `PIPE_LAT`, 6, cycles from generator output to accumulator input. Also the clear length.
- `MERGE_LAT`, 3, cycles from lane accumulator update to merged sum valid.
- `CNT_W`, 32, width of the per-lane sample counter.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle run request. Sampled only in IDLE.
- `abort`  in  1  cancel current run. Honoured in any state.
- `sample_target`  in  CNT_W  samples per lane. Latched on accepted start.
- `sum_in`  in  64  merged sum from the merge stage.
- `sum_sq_in`  in  64  merged sum of squares from the merge stage.
- `mc_status`  out  1  accumulate enable to every lane (`Status`).
- `mc_mode`  out  1  synchronous accumulator clear to every lane (`Mode`).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when results become valid.
- `aborted`  out  1  one-cycle pulse on an honoured abort.
- `err_zero`  out  1  one-cycle pulse when start arrives with `sample_target` = 0.
- `result_sum`  out  64  captured sum.
- `result_sum_sq`  out  64  captured sum of squares.
- `result_count`  out  CNT_W+3  `sample_target` × `LANES`.
- `result_valid`  out  1  high from `done` until the next accepted start or reset.

## Operation
- States: IDLE, CLEAR, WARMUP, RUN, DRAIN, CAPTURE.
- IDLE:
  - `start` with a nonzero target: latch the target, clear `result_valid`, go to CLEAR.
  - `start` with target 0: pulse `err_zero`, stay in IDLE, results untouched.
- CLEAR: `mc_mode`=1, `mc_status`=0 for `PIPE_LAT` cycles, then go to WARMUP.
- WARMUP: both lines low for `PIPE_LAT` cycles, so only post-reset-seed samples reach the accumulators. Then go to RUN.
- RUN: `mc_status`=1 for exactly `sample_target` cycles, counted by the down-counter `remaining`. Leave for DRAIN when `remaining` reaches 1.
- DRAIN: `mc_status`=0 for `MERGE_LAT`+1 cycles.
- CAPTURE (1 cycle):
  - Register `sum_in`, `sum_sq_in` and `result_count`.
  - Set `result_valid`, pulse `done`, go to IDLE.
- Abort, in any non-IDLE state:
  - Next state is IDLE; `mc_status` and `mc_mode` drop on the next edge.
  - Pulse `aborted`. No `done`; `result_valid` stays 0.
- Abort in IDLE is ignored (no pulse).
- `start` and `abort` together in IDLE: abort wins and start is dropped. No pulses, no state change.
- `start` while busy is ignored. `sample_target` changes after acceptance have no effect.
- `result_count` is computed with full width; no overflow is possible at CNT_W+3 for `LANES` ≤ 8.
- Reset: state IDLE, all outputs 0, counters 0.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Start accepted at edge 0, so `mc_mode`=1 over cycles 1…`PIPE_LAT`.
- `mc_status`=1 over cycles 2·`PIPE_LAT`+1 … 2·`PIPE_LAT`+`sample_target`.
- `done` and `result_valid` rise at cycle 2·`PIPE_LAT`+`sample_target`+`MERGE_LAT`+3.
- Total latency for defaults: `sample_target`+18 cycles.
- Back-to-back runs: a start in the cycle after `done` is accepted.
- A reset asserted mid-run returns to IDLE immediately, without waiting for a clock edge.

## Structure
- Shared package `mc_pkg`:
  - state enum;
  - default `LANES`, `PIPE_LAT`, `MERGE_LAT`;
  - 64-bit accumulator width constant (reused by the math and merge blocks).
- One sub-module: `mc_phase_counter`, a loadable down-counter with a terminal flag. It is reused for the CLEAR, WARMUP, RUN and DRAIN phase lengths.

## Test plan
- Reset, then start with `sample_target`=10 and `sum_in`=0x1234 held:
  - `mc_mode` high for cycles 1–6;
  - `mc_status` high for cycles 13–22;
  - `done` at cycle 28;
  - `result_sum`=0x1234, `result_count`=50.
- Start with `sample_target`=0: `err_zero` pulses, `busy` stays 0, previous results unchanged.
- Abort during RUN at cycle 15 of a 100-sample run:
  - `mc_status` low at cycle 16;
  - `aborted` pulses;
  - no `done`, `result_valid`=0.
- `start` pulsed during RUN: no effect, and `done` timing is identical to an undisturbed run.
- Start and abort in the same IDLE cycle: no state change, no pulses.
- Async reset asserted mid-WARMUP, between clock edges: `busy`, `mc_mode` and `mc_status` go to 0 before the next edge.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants and types for the Monte Carlo run sequencer and its datapath.
package mc_pkg;
  localparam int LANES_DEF     = 5;
  localparam int PIPE_LAT_DEF  = 6;
  localparam int MERGE_LAT_DEF = 3;
  localparam int ACC_W         = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WARMUP, S_RUN, S_DRAIN, S_CAPTURE
  } state_t;
endpackage

// File: rtl/mc_phase_counter.sv
// Loadable down-counter; last flags the final cycle of a loaded phase.
module mc_phase_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         last
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - W'(1);
  end

  assign last = (count == W'(1));
endmodule

// File: rtl/mc_run_controller.sv
// Run sequencer: clear, warm up, accumulate for sample_target cycles, drain,
// then capture the merged sums into stable result registers.
module mc_run_controller
  import mc_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int MERGE_LAT = MERGE_LAT_DEF,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] sample_target,
  input  logic [ACC_W-1:0] sum_in,
  input  logic [ACC_W-1:0] sum_sq_in,
  output logic             mc_status,
  output logic             mc_mode,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err_zero,
  output logic [ACC_W-1:0] result_sum,
  output logic [ACC_W-1:0] result_sum_sq,
  output logic [CNT_W+2:0] result_count,
  output logic             result_valid
);
  localparam int RW = CNT_W + 3;

  state_t           state, next;
  logic [CNT_W-1:0] target_q, remaining, load_val;
  logic             load, last, accept;
  logic             status_d, mode_d, busy_d, done_d, aborted_d, err_d;

  assign accept = (state == S_IDLE) && start && !abort && (sample_target != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    if (abort && state != S_IDLE) next = S_IDLE;
    else begin
      case (state)
        S_IDLE:    if (accept) next = S_CLEAR;
        S_CLEAR:   if (last)   next = S_WARMUP;
        S_WARMUP:  if (last)   next = S_RUN;
        S_RUN:     if (last)   next = S_DRAIN;
        S_DRAIN:   if (last)   next = S_CAPTURE;
        S_CAPTURE:             next = S_IDLE;
        default:               next = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from next so the registered lines line up with the state.
  always_comb begin
    mode_d    = (next == S_CLEAR);
    status_d  = (next == S_RUN);
    busy_d    = (next != S_IDLE);
    done_d    = (state == S_CAPTURE) && !abort;
    aborted_d = abort && (state != S_IDLE);
    err_d     = (state == S_IDLE) && start && !abort && (sample_target == '0);
  end

  // The phase counter is reloaded on every state change with the new phase length.
  always_comb begin
    load = (next != state);
    case (next)
      S_CLEAR, S_WARMUP: load_val = CNT_W'(PIPE_LAT);
      S_RUN:             load_val = target_q;
      S_DRAIN:           load_val = CNT_W'(MERGE_LAT + 1);
      default:           load_val = '0;
    endcase
  end

  mc_phase_counter #(.W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .count    (remaining),
    .last     (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_status <= 1'b0;
      mc_mode   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      err_zero  <= 1'b0;
    end else begin
      mc_status <= status_d;
      mc_mode   <= mode_d;
      busy      <= busy_d;
      done      <= done_d;
      aborted   <= aborted_d;
      err_zero  <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q      <= '0;
      result_sum    <= '0;
      result_sum_sq <= '0;
      result_count  <= '0;
      result_valid  <= 1'b0;
    end else if (accept) begin
      target_q     <= sample_target;
      result_valid <= 1'b0;
    end else if (done_d) begin
      result_sum    <= sum_in;
      result_sum_sq <= sum_sq_in;
      result_count  <= RW'(target_q) * RW'(LANES);
      result_valid  <= 1'b1;
    end
  end
endmodule
